instr_decode_pipe: RTL and testbench



---
 rtl/riscv_decode_pkg.sv | 59 +++++
 rtl/instr_imm_gen.sv | 70 +++++++
 rtl/instr_decode_pipe.sv | 164 ++++++++++++++++
 tb/tb_instr_decode_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats,
// instruction field positions and operand-use helpers.
package riscv_decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  // rs1 is read by R, I, S and B formats
  function automatic logic uses_rs1(input logic [6:0] op);
    logic r;
    case (op)
      OP_REG, OP_LOAD, OP_IMM, OP_JALR,
      OP_SYSTEM, OP_STORE, OP_BRANCH: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // rs2 is read by R, S and B formats
  function automatic logic uses_rs2(input logic [6:0] op);
    logic r;
    case (op)
      OP_REG, OP_STORE, OP_BRANCH: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_imm_gen.sv
// Combinational immediate extraction and format
// classification; unknown opcodes are flagged illegal.
module instr_imm_gen
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  logic [6:0]  w_op;
  logic [31:0] w_imm;
  imm_fmt_e    w_fmt;
  logic        w_unknown;

  assign w_op = i_instr[OPC_MSB:OPC_LSB];

  // Opcode-driven format select and immediate assembly
  always_comb begin
    w_imm     = '0;
    w_fmt     = FMT_NONE;
    w_unknown = 1'b0;
    unique case (w_op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        w_fmt = FMT_I;
        w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        w_fmt = FMT_S;
        w_imm = {{20{i_instr[31]}}, i_instr[31:25],
                 i_instr[11:7]};
      end
      OP_BRANCH: begin
        w_fmt = FMT_B;
        w_imm = {{19{i_instr[31]}}, i_instr[31],
                 i_instr[7], i_instr[30:25],
                 i_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt = FMT_U;
        w_imm = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_fmt = FMT_J;
        w_imm = {{11{i_instr[31]}}, i_instr[31],
                 i_instr[19:12], i_instr[20],
                 i_instr[30:21], 1'b0};
      end
      OP_REG: begin
        w_fmt = FMT_NONE;
      end
      default: begin
        w_unknown = 1'b1;
      end
    endcase
    if (i_instr[1:0] != 2'b11) begin
      w_unknown = 1'b1;
      w_imm     = '0;
      w_fmt     = FMT_NONE;
    end
  end

  assign o_imm     = XLEN'($signed(w_imm));
  assign o_fmt     = w_fmt;
  assign o_illegal = w_unknown;

endmodule

// File: rtl/instr_decode_pipe.sv
// Decode stage: handshake, load-use stall, flush,
// registered decode and priority operand forwarding.
module instr_decode_pipe
  import riscv_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_FWD    = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [XLEN-1:0]               pc_i,
  input  logic [31:0]                   instr_i,
  output logic [REG_ADDR_W-1:0]         rs1_addr_o,
  output logic [REG_ADDR_W-1:0]         rs2_addr_o,
  output logic                          rs_read_en_o,
  input  logic [XLEN-1:0]               rs1_data_i,
  input  logic [XLEN-1:0]               rs2_data_i,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data_i,
  input  logic                          ex_load_valid_i,
  input  logic [REG_ADDR_W-1:0]         ex_load_rd_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [XLEN-1:0]               pc_o,
  output logic [6:0]                    opcode_o,
  output logic [REG_ADDR_W-1:0]         rd_addr_o,
  output logic [2:0]                    funct3_o,
  output logic [6:0]                    funct7_o,
  output logic [XLEN-1:0]               rs1_data_o,
  output logic [XLEN-1:0]               rs2_data_o,
  output logic [XLEN-1:0]               imm_o,
  output logic [2:0]                    imm_fmt_o,
  output logic                          illegal_o
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [6:0]            r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [2:0]            r_f3;
  logic [6:0]            r_f7;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [XLEN-1:0]       r_imm;
  logic [2:0]            r_fmt;
  logic                  r_ill;

  logic [6:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]       w_imm;
  logic [2:0]            w_fmt;
  logic                  w_ill;
  logic                  w_hz;
  logic                  w_fire;

  assign w_op  = instr_i[OPC_MSB:OPC_LSB];
  assign w_rs1 = REG_ADDR_W'(instr_i[RS1_MSB:RS1_LSB]);
  assign w_rs2 = REG_ADDR_W'(instr_i[RS2_MSB:RS2_LSB]);

  instr_imm_gen #(
    .XLEN(XLEN)
  ) u_imm (
    .i_instr  (instr_i),
    .o_imm    (w_imm),
    .o_fmt    (w_fmt),
    .o_illegal(w_ill)
  );

  // Stores and branches write no register
  assign w_rd = (w_ill || w_fmt == FMT_S ||
                 w_fmt == FMT_B) ? '0 :
                REG_ADDR_W'(instr_i[RD_MSB:RD_LSB]);

  assign w_hz = ex_load_valid_i &&
                ex_load_rd_i != '0 &&
                ((uses_rs1(w_op) && ex_load_rd_i == w_rs1) ||
                 (uses_rs2(w_op) && ex_load_rd_i == w_rs2));

  assign in_ready_o = flush_i ||
                      (!w_hz && (!r_valid || out_ready_i));
  assign w_fire     = in_valid_i && in_ready_o;

  // Output register: reset, flush, load, drain, hold
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_f3    <= '0;
      r_f7    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_fmt   <= '0;
      r_ill   <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_pc    <= pc_i;
      r_op    <= w_op;
      r_rd    <= w_rd;
      r_f3    <= instr_i[F3_MSB:F3_LSB];
      r_f7    <= instr_i[F7_MSB:F7_LSB];
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_imm   <= w_imm;
      r_fmt   <= w_fmt;
      r_ill   <= w_ill;
    end else if (out_ready_i || !r_valid) begin
      r_valid <= 1'b0;
    end
  end

  // Address follows the incoming instruction only when it
  // is taken, so read data always matches the held one.
  assign rs1_addr_o   = w_fire ? w_rs1 : r_rs1;
  assign rs2_addr_o   = w_fire ? w_rs2 : r_rs2;
  assign rs_read_en_o = !reset_i;

  logic [NUM_FWD-1:0] w_m1;
  logic [NUM_FWD-1:0] w_m2;
  logic [XLEN-1:0]    w_op1;
  logic [XLEN-1:0]    w_op2;

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
    assign w_m1[g] = fwd_valid_i[g] &&
      fwd_addr_i[g*REG_ADDR_W +: REG_ADDR_W] == r_rs1;
    assign w_m2[g] = fwd_valid_i[g] &&
      fwd_addr_i[g*REG_ADDR_W +: REG_ADDR_W] == r_rs2;
  end

  // Lowest matching index wins; scanned high to low
  always_comb begin
    w_op1 = rs1_data_i;
    w_op2 = rs2_data_i;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_m1[i]) w_op1 = fwd_data_i[i*XLEN +: XLEN];
      if (w_m2[i]) w_op2 = fwd_data_i[i*XLEN +: XLEN];
    end
  end

  assign rs1_data_o  = (r_rs1 == '0) ? '0 : w_op1;
  assign rs2_data_o  = (r_rs2 == '0) ? '0 : w_op2;

  assign out_valid_o = r_valid;
  assign pc_o        = r_pc;
  assign opcode_o    = r_op;
  assign rd_addr_o   = r_rd;
  assign funct3_o    = r_f3;
  assign funct7_o    = r_f7;
  assign imm_o       = r_imm;
  assign imm_fmt_o   = r_fmt;
  assign illegal_o   = r_ill;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Randomised bench for instr_decode_pipe against an
// instruction-level reference model and register file.
module tb_instr_decode_pipe;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NF = 2;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [XL-1:0] pc;
  logic [31:0]   instr;
  logic [AW-1:0] rs1_a, rs2_a;
  logic          rd_en;
  logic [XL-1:0] rs1_d, rs2_d;
  logic [NF-1:0] fv;
  logic [NF*AW-1:0] fa;
  logic [NF*XL-1:0] fd;
  logic          ld_v;
  logic [AW-1:0] ld_rd;
  logic          out_valid, out_ready;
  logic [XL-1:0] pc_o, rs1_o, rs2_o, imm_o;
  logic [6:0]    opc_o, f7_o;
  logic [AW-1:0] rd_o;
  logic [2:0]    f3_o, fmt_o;
  logic          ill_o;

  instr_decode_pipe #(
    .XLEN(XL), .REG_ADDR_W(AW), .NUM_FWD(NF)
  ) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .instr_i(instr),
    .rs1_addr_o(rs1_a), .rs2_addr_o(rs2_a),
    .rs_read_en_o(rd_en),
    .rs1_data_i(rs1_d), .rs2_data_i(rs2_d),
    .fwd_valid_i(fv), .fwd_addr_i(fa), .fwd_data_i(fd),
    .ex_load_valid_i(ld_v), .ex_load_rd_i(ld_rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .opcode_o(opc_o), .rd_addr_o(rd_o),
    .funct3_o(f3_o), .funct7_o(f7_o),
    .rs1_data_o(rs1_o), .rs2_data_o(rs2_o),
    .imm_o(imm_o), .imm_fmt_o(fmt_o), .illegal_o(ill_o)
  );

  always #5 clk = ~clk;

  logic [XL-1:0] regs [32];

  // Register file: data one cycle after the address
  always @(posedge clk) begin
    rs1_d <= regs[rs1_a];
    rs2_d <= regs[rs2_a];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // fmt: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J
  function automatic void ref_dec(input logic [31:0] x,
                                  output int f,
                                  output logic [31:0] im,
                                  output logic il);
    int v;
    v = 0; f = 0; il = 1'b0; im = '0;
    case (x[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        f = 1; v = x[31:20];
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        f = 2; v = x[31:25] * 32 + x[11:7];
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        f = 3;
        v = x[31] * 4096 + x[7] * 2048 +
            x[30:25] * 32 + x[11:8] * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: f = 4;
      7'h6F: begin
        f = 5;
        v = x[31] * (1 << 20) + x[19:12] * (1 << 12) +
            x[20] * 2048 + x[30:21] * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      7'h33: f = 0;
      default: il = 1'b1;
    endcase
    im = (f == 4) ? (x & 32'hFFFF_F000) : 32'(v);
  endfunction

  function automatic logic [XL-1:0] opnd(input logic [4:0] r);
    if (r == 0) return '0;
    for (int i = 0; i < NF; i++)
      if (fv[i] && fa[i*AW +: AW] == r)
        return fd[i*XL +: XL];
    return regs[r];
  endfunction

  logic        m_valid = 1'b0;
  logic        m_loaded = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;

  task automatic step();
    int f, fi;
    logic [31:0] im, imi;
    logic il, ili, u1, u2, hz, rdy, fire;
    logic [4:0] h1, h2;
    @(negedge clk);
    ref_dec(m_instr, f, im, il);
    ref_dec(instr, fi, imi, ili);
    u1 = !ili && fi <= 3;
    u2 = !ili && (fi == 0 || fi == 2 || fi == 3);
    hz = ld_v && ld_rd != 0 &&
         ((u1 && ld_rd == instr[19:15]) ||
          (u2 && ld_rd == instr[24:20]));
    rdy  = flush || (!hz && (!m_valid || out_ready));
    fire = in_valid && rdy;
    h1 = m_loaded ? m_instr[19:15] : 5'd0;
    h2 = m_loaded ? m_instr[24:20] : 5'd0;
    chk("rd_en", rd_en, !reset);
    if (!reset) begin
      chk("in_rdy", in_ready, rdy);
      chk("o_val", out_valid, m_valid);
      chk("rs1_a", rs1_a, fire ? instr[19:15] : h1);
      chk("rs2_a", rs2_a, fire ? instr[24:20] : h2);
      chk("pc", pc_o, m_pc);
      chk("op", opc_o, m_instr[6:0]);
      chk("f3", f3_o, m_instr[14:12]);
      chk("f7", f7_o, m_instr[31:25]);
      chk("rd", rd_o,
          (!m_loaded || il || f == 2 || f == 3) ?
          5'd0 : m_instr[11:7]);
      chk("imm", imm_o, m_loaded ? im : 32'd0);
      chk("fmt", fmt_o, m_loaded ? f : 0);
      chk("ill", ill_o, m_loaded && il);
      if (m_valid) begin
        chk("rs1_d", rs1_o, opnd(h1));
        chk("rs2_d", rs2_o, opnd(h2));
      end
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_loaded = 0; m_instr = '0; m_pc = '0;
    end else if (flush) begin
      m_valid = 0;
    end else if (fire) begin
      m_valid = 1; m_loaded = 1;
      m_instr = instr; m_pc = pc;
    end else if (out_ready || !m_valid) begin
      m_valid = 0;
    end
    #1;
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73,
    7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  task automatic rand_inputs();
    logic [31:0] r;
    int k;
    reset     = ($urandom_range(0, 499) == 0);
    flush     = ($urandom_range(0, 19) == 0);
    in_valid  = ($urandom_range(0, 9) < 7);
    out_ready = ($urandom_range(0, 9) < 7);
    ld_v      = ($urandom_range(0, 3) == 0);
    ld_rd     = 5'($urandom_range(0, 3));
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 10);
    r[6:0] = (k == 10) ? 7'($urandom) : ops[k];
    instr = r;
    pc = $urandom;
    fv = NF'($urandom);
    for (int i = 0; i < NF; i++) begin
      fa[i*AW +: AW] = 5'($urandom_range(0, 3));
      fd[i*XL +: XL] = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    pc = '0; instr = '0; fv = '0; fa = '0; fd = '0;
    ld_v = 0; ld_rd = '0;
    repeat (3) step();
    reset = 0;
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_val", out_valid, 0);
    chk("rst_imm", imm_o, 0);
    step();

    in_valid = 1; pc = 32'h100; instr = 32'hFFF00293;
    step();
    in_valid = 0;
    chk("addi_v", out_valid, 1);
    chk("addi_op", opc_o, 7'h13);
    chk("addi_rd", rd_o, 5);
    chk("addi_imm", imm_o, 32'hFFFF_FFFF);
    chk("addi_fmt", fmt_o, 1);
    chk("addi_pc", pc_o, 32'h100);

    in_valid = 1; pc = 32'h104; instr = 32'h002081B3;
    step();
    out_ready = 0; pc = 32'h108; instr = 32'h00000013;
    repeat (3) step();
    chk("bp_rdy", in_ready, 0);
    chk("bp_rs1", rs1_a, 1);
    chk("bp_rs2", rs2_a, 2);
    chk("bp_pc", pc_o, 32'h104);
    fv = 2'b11; fa = {5'd1, 5'd1};
    fd = {32'hBBBB, 32'hAAAA};
    #1 chk("fwd_pri", rs1_o, 32'hAAAA);
    fa = {5'd2, 5'd1}; fd = {32'h5, 32'hAAAA};
    #1 chk("fwd_rs1", rs1_o, 32'hAAAA);
    chk("fwd_rs2", rs2_o, 32'h5);
    step();

    fv = '0; in_valid = 1; out_ready = 1;
    instr = 32'h002081B3; pc = 32'h10C;
    ld_v = 1; ld_rd = 1;
    #1 chk("hz_rdy", in_ready, 0);
    step();
    chk("hz_bub", out_valid, 0);
    ld_v = 0;
    step();
    chk("hz_go", out_valid, 1);
    chk("hz_pc", pc_o, 32'h10C);

    instr = 32'hFFF00293; pc = 32'h200;
    step();
    in_valid = 0; out_ready = 0;
    fv = 2'b01; fa = {5'd3, 5'd0}; fd = {32'h0, 32'h7};
    #1 chk("fwd_x0", rs1_o, 0);
    step();

    fv = '0; flush = 1; in_valid = 1;
    instr = 32'h002081B3; pc = 32'h300;
    step();
    flush = 0; in_valid = 0;
    chk("fl_val", out_valid, 0);
    step();
    chk("fl_drop", pc_o, 32'h200);

    out_ready = 1; in_valid = 1;
    instr = 32'h0000007F; pc = 32'h400;
    step();
    in_valid = 0;
    chk("il_v", out_valid, 1);
    chk("il_ill", ill_o, 1);
    chk("il_imm", imm_o, 0);
    chk("il_rd", rd_o, 0);
    step();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
